// File: rtl/video_pattern_pkg.sv
// Shared types and constants for the video test-pattern source.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   pat_mode_e  - runtime pattern select
//   tg_state_e  - timing FSM state
//   bar_level() - colorbar intensity for bar b at a given pixel width
package video_pattern_pkg;

    typedef enum logic [1:0] {
        PAT_RAMP  = 2'd0,
        PAT_BAR   = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_FRAME = 2'd3
    } pat_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tg_state_e;

    localparam int NUM_BARS = 8;

    // Descending intensity: bar 0 is full scale, the last bar is black.
    // Evaluated at elaboration only, so the divide never reaches silicon.
    function automatic int bar_level(input int b, input int data_w);
        return ((NUM_BARS - 1 - b) * ((1 << data_w) - 1)) / (NUM_BARS - 1);
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster timing: col/row counters, IDLE/RUN FSM, registered fv/lv/sof, frame counter.
// Latency: fv/lv/sof are registered, one cycle behind the counter state they describe.
// Backpressure: none; free-running once started, en/mode only take effect at frame boundaries.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   en, mode        - run request and pattern select, sampled at frame start
//   active          - current counter state is an active beat (combinational)
//   beat, line      - active-region beat/line index of the current state (valid while active)
//   mode_q          - pattern latched for the current frame
//   fv, lv, sof     - registered framing
//   frame_cnt       - completed-frame count
module video_timing_gen
    import video_pattern_pkg::*;
#(
    parameter int H_ACTIVE = 1920,
    parameter int H_BLANK  = 190,
    parameter int V_ACTIVE = 1080,
    parameter int V_BLANK  = 74,
    parameter int FCNT_W   = 16,
    localparam int CW      = $clog2(H_BLANK + H_ACTIVE),
    localparam int RW      = $clog2(V_BLANK + V_ACTIVE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    output logic              active,
    output logic [CW-1:0]     beat,
    output logic [RW-1:0]     line,
    output pat_mode_e         mode_q,
    output logic              fv,
    output logic              lv,
    output logic              sof,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam logic [CW-1:0] COL_LAST = CW'(H_BLANK + H_ACTIVE - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(V_BLANK + V_ACTIVE - 1);
    localparam logic [CW-1:0] COL_ACT0 = CW'(H_BLANK);
    localparam logic [RW-1:0] ROW_ACT0 = RW'(V_BLANK);

    tg_state_e     state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          in_vact;

    assign in_vact = (state == ST_RUN) && (row >= ROW_ACT0);
    assign active  = in_vact && (col >= COL_ACT0);
    assign beat    = col - COL_ACT0;
    assign line    = row - ROW_ACT0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            col       <= '0;
            row       <= '0;
            mode_q    <= PAT_RAMP;
            frame_cnt <= '0;
            fv        <= 1'b0;
            lv        <= 1'b0;
            sof       <= 1'b0;
        end else begin
            // fv spans the whole of each active row, horizontal blanking included.
            fv  <= in_vact;
            lv  <= active;
            sof <= active && (row == ROW_ACT0) && (col == COL_ACT0);

            unique case (state)
                ST_IDLE: begin
                    col <= '0;
                    row <= '0;
                    if (en) begin
                        state  <= ST_RUN;
                        mode_q <= pat_mode_e'(mode);
                    end
                end
                ST_RUN: begin
                    if (col == COL_LAST) begin
                        col <= '0;
                        if (row == ROW_LAST) begin
                            row       <= '0;
                            frame_cnt <= frame_cnt + 1'b1;
                            // Next frame starts straight away; pattern is re-sampled here only.
                            if (en) begin
                                mode_q <= pat_mode_e'(mode);
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            row <= row + 1'b1;
                        end
                    end else begin
                        col <= col + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern video source: framing from video_timing_gen plus PPC parallel pattern lanes.
// Latency: one cycle from counter state to fv/lv/sof/data (all registered together).
// Backpressure: none; the sink must accept a beat every cycle lv is high.
//
// Ports:
//   clk, rst   - pixel clock, synchronous active-high reset
//   en, mode   - run request and pattern select (0 ramp, 1 colorbar, 2 checker, 3 frame solid)
//   data       - PPC lanes, lane k at [k*DATA_W +: DATA_W], lane 0 leftmost; zero outside lv
//   fv, lv     - frame/line valid
//   sof        - pulse on first active beat of each frame
//   frame_cnt  - completed-frame count
module video_pattern_gen
    import video_pattern_pkg::*;
#(
    parameter int DATA_W     = 10,
    parameter int PPC        = 1,
    parameter int H_ACTIVE   = 1920,
    parameter int H_BLANK    = 190,
    parameter int V_ACTIVE   = 1080,
    parameter int V_BLANK    = 74,
    parameter int CHECK_LOG2 = 5,
    parameter int FCNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [1:0]            mode,
    output logic [PPC*DATA_W-1:0] data,
    output logic                  fv,
    output logic                  lv,
    output logic                  sof,
    output logic [FCNT_W-1:0]     frame_cnt
);

    localparam int CW    = $clog2(H_BLANK + H_ACTIVE);
    localparam int RW    = $clog2(V_BLANK + V_ACTIVE);
    localparam int BAR_W = (H_ACTIVE * PPC) / NUM_BARS;
    localparam logic [31:0] CHK_MASK = 32'd1 << CHECK_LOG2;

    if (((H_ACTIVE * PPC) % NUM_BARS) != 0 || DATA_W <= 0 || PPC <= 0 ||
        H_ACTIVE <= 0 || H_BLANK <= 0 || V_ACTIVE <= 0 || V_BLANK <= 0 ||
        CHECK_LOG2 <= 0 || FCNT_W <= 0) begin : g_bad_params
        $error("video_pattern_gen: illegal parameter set");
    end

    logic                  active;
    logic [CW-1:0]         beat;
    logic [RW-1:0]         line;
    pat_mode_e             mode_q;
    logic [PPC*DATA_W-1:0] pix_nxt;
    logic [DATA_W-1:0]     fcnt_pix;
    logic [DATA_W-1:0]     lvl [NUM_BARS];
    logic                  y_chk;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_BLANK  (H_BLANK),
        .V_ACTIVE (V_ACTIVE),
        .V_BLANK  (V_BLANK),
        .FCNT_W   (FCNT_W)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .active    (active),
        .beat      (beat),
        .line      (line),
        .mode_q    (mode_q),
        .fv        (fv),
        .lv        (lv),
        .sof       (sof),
        .frame_cnt (frame_cnt)
    );

    for (genvar j = 0; j < NUM_BARS; j++) begin : g_lvl
        assign lvl[j] = DATA_W'(bar_level(j, DATA_W));
    end

    // Size cast truncates or zero-extends the counter to pixel width.
    assign fcnt_pix = DATA_W'(frame_cnt);
    assign y_chk    = |(32'(line) & CHK_MASK);

    for (genvar k = 0; k < PPC; k++) begin : g_lane
        logic [31:0]       x;
        logic              x_chk;
        logic [DATA_W-1:0] bar_pix;
        logic [DATA_W-1:0] pix;

        assign x     = 32'(beat) * 32'(PPC) + 32'(k);
        assign x_chk = |(x & CHK_MASK);

        // Bar index by threshold comparison; anything past the last edge stays on the last bar.
        always_comb begin
            bar_pix = lvl[0];
            for (int j = 1; j < NUM_BARS; j++) begin
                if (x >= 32'(j * BAR_W)) begin
                    bar_pix = lvl[3'(j)];
                end
            end
        end

        always_comb begin
            pix = '0;
            unique case (mode_q)
                PAT_RAMP:  pix = x[DATA_W-1:0];
                PAT_BAR:   pix = bar_pix;
                PAT_CHECK: pix = (x_chk ^ y_chk) ? '1 : '0;
                PAT_FRAME: pix = fcnt_pix;
            endcase
        end

        assign pix_nxt[k*DATA_W +: DATA_W] = pix;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else begin
            data <= active ? pix_nxt : '0;
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
module tb_video_pattern_gen;

    localparam int DW = 10;
    localparam int PPC = 2;
    localparam int HA = 8;
    localparam int HB = 4;
    localparam int VA = 4;
    localparam int VB = 2;
    localparam int CL = 1;
    localparam int FW = 16;
    localparam int HT = HA + HB;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [1:0]        mode;
    logic [PPC*DW-1:0] data;
    logic              fv;
    logic              lv;
    logic              sof;
    logic [FW-1:0]     frame_cnt;

    always #5 clk = ~clk;

    video_pattern_gen #(
        .DATA_W     (DW),
        .PPC        (PPC),
        .H_ACTIVE   (HA),
        .H_BLANK    (HB),
        .V_ACTIVE   (VA),
        .V_BLANK    (VB),
        .CHECK_LOG2 (CL),
        .FCNT_W     (FW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .data      (data),
        .fv        (fv),
        .lv        (lv),
        .sof       (sof),
        .frame_cnt (frame_cnt)
    );

    typedef struct packed {
        logic [PPC*DW-1:0] d;
        logic              s;
    } beat_t;

    beat_t exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    fv_hi = 0;
    int    lv_hi = 0;
    int    sof_n = 0;
    int    lv_rise = 0;
    logic  lv_prev = 1'b0;

    // 10-bit colorbar levels, floor((7-b)*1023/7), one bar per beat at PPC=2.
    int bar_lvl [8] = '{1023, 876, 730, 584, 438, 292, 146, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the 32 active beats of one frame (4 lines x 8 beats, 2 lanes each).
    task automatic push_frame(input int m, input int fnum);
        beat_t b;
        int    l0;
        int    l1;
        for (int y = 0; y < VA; y++) begin
            for (int i = 0; i < HA; i++) begin
                l0 = 0;
                l1 = 0;
                case (m)
                    0: begin l0 = 2 * i; l1 = 2 * i + 1; end
                    1: begin l0 = bar_lvl[i]; l1 = bar_lvl[i]; end
                    2: begin
                        l0 = (((i & 1) ^ ((y >> 1) & 1)) != 0) ? 1023 : 0;
                        l1 = l0;
                    end
                    default: begin l0 = fnum; l1 = fnum; end
                endcase
                b.d = {DW'(l1), DW'(l0)};
                b.s = (y == 0) && (i == 0);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic monitor();
        beat_t e;
        forever begin
            @(negedge clk);
            if (fv) fv_hi++;
            if (lv) lv_hi++;
            if (sof) sof_n++;
            if (lv && !lv_prev) lv_rise++;
            lv_prev = lv;
            if (lv) begin
                chk("lv_within_fv", 32'(fv), 32'd1);
                chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("beat_data", 32'(data), 32'(e.d));
                    chk("beat_sof", 32'(sof), 32'(e.s));
                end
            end else begin
                chk("data_zero_outside_lv", 32'(data), 32'd0);
                chk("sof_outside_lv", 32'(sof), 32'd0);
            end
        end
    endtask

    task automatic wait_fcnt(input int target, input int budget, input string name);
        int n = 0;
        while (32'(frame_cnt) != target && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(frame_cnt), target);
    endtask

    initial begin
        int s_fv;
        int s_lv;
        int s_sof;
        int s_rise;
        int n;

        fork
            monitor();
        join_none

        rst  = 1'b1;
        en   = 1'b1;
        mode = 2'd0;
        repeat (3) tick();
        chk("reset_fv", 32'(fv), 0);
        chk("reset_lv", 32'(lv), 0);
        chk("reset_sof", 32'(sof), 0);
        chk("reset_data", 32'(data), 0);
        chk("reset_fcnt", 32'(frame_cnt), 0);

        // Ramp frame; en dropped mid-frame so exactly one frame runs.
        push_frame(0, 0);
        s_fv = fv_hi; s_lv = lv_hi; s_sof = sof_n; s_rise = lv_rise;
        rst = 1'b0;
        repeat (10) tick();
        en = 1'b0;
        wait_fcnt(1, 200, "ramp_frame_end");
        repeat (5) tick();
        chk("ramp_fv_cycles", 32'(fv_hi - s_fv), 48);
        chk("ramp_lv_cycles", 32'(lv_hi - s_lv), 32);
        chk("ramp_sof_count", 32'(sof_n - s_sof), 1);
        chk("ramp_lv_bursts", 32'(lv_rise - s_rise), 4);
        chk("ramp_idle_fv", 32'(fv), 0);

        // Colorbar frame.
        push_frame(1, 1);
        mode = 2'd1;
        en = 1'b1;
        repeat (10) tick();
        en = 1'b0;
        wait_fcnt(2, 200, "bar_frame_end");
        repeat (5) tick();

        // Checkerboard frame.
        push_frame(2, 2);
        mode = 2'd2;
        en = 1'b1;
        repeat (10) tick();
        en = 1'b0;
        wait_fcnt(3, 200, "check_frame_end");
        repeat (5) tick();

        // Three frame-solid frames, mode flipped to ramp in the middle of the third.
        push_frame(3, 3);
        push_frame(3, 4);
        push_frame(3, 5);
        push_frame(0, 0);
        mode = 2'd3;
        en = 1'b1;
        wait_fcnt(5, 400, "solid_second_end");
        repeat (30) tick();
        mode = 2'd0;
        wait_fcnt(6, 200, "solid_third_end");
        repeat (40) tick();
        en = 1'b0;
        wait_fcnt(7, 200, "ramp_after_solid_end");
        repeat (5) tick();
        chk("idle_after_drop_fv", 32'(fv), 0);
        chk("idle_after_drop_lv", 32'(lv), 0);
        s_fv = fv_hi;
        repeat (50) tick();
        chk("idle_fcnt_held", 32'(frame_cnt), 7);
        chk("idle_no_fv", 32'(fv_hi - s_fv), 0);

        // Restart: fv rises V_BLANK*H_TOTAL+1 edges after the edge that samples en.
        push_frame(0, 0);
        en = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!fv && n < 100);
        chk("fv_rise_delay", 32'(n - 1), VB * HT + 1);

        n = 0;
        while (!lv && n < 100) begin
            tick();
            n++;
        end
        chk("lv_reached", 32'(lv), 1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        exp_q.delete();
        chk("midline_rst_fv", 32'(fv), 0);
        chk("midline_rst_lv", 32'(lv), 0);
        chk("midline_rst_sof", 32'(sof), 0);
        chk("midline_rst_data", 32'(data), 0);
        chk("midline_rst_fcnt", 32'(frame_cnt), 0);

        // Clean checker frame straight out of reset.
        push_frame(2, 0);
        mode = 2'd2;
        rst = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!fv && n < 100);
        chk("fv_rise_after_rst", 32'(n - 1), VB * HT + 1);
        repeat (10) tick();
        en = 1'b0;
        wait_fcnt(1, 200, "post_rst_frame_end");
        repeat (5) tick();
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
